// File: rtl/add_pkg.sv
// Shared defaults and FSM encoding for the serial adder/subtractor.
package add_pkg;

    localparam int ADD_WIDTH_DEF = 16;
    localparam int ADD_CHUNK_DEF = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/add_serial_if.sv
// start/busy/done request bundle with operands and result.
interface add_serial_if
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEF
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/add_serial.sv
// Multi-cycle add/sub, CHUNK bits per clock, LSB chunk first.
// Define ADD_SERIAL_SAT_EN to saturate sum on signed overflow.
module add_serial
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEF,
    parameter int CHUNK = ADD_CHUNK_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    add_serial_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_msb;
    logic [WIDTH-1:0] s_ext;
    logic [WIDTH-1:0] r_next;

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .ci    (c_q),
        .s     (s),
        .co    (co),
        .c_msb (c_msb)
    );

    // New chunk enters at the top; after NCHUNK shifts it is aligned.
    always_comb begin
        s_ext            = '0;
        s_ext[CHUNK-1:0] = s;
        r_next = (r_q >> CHUNK) | (s_ext << (WIDTH - CHUNK));
    end

`ifdef ADD_SERIAL_SAT_EN
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SMAX = ~SMIN;

    // On the last chunk a_q[CHUNK-1] is the original sign of A.
    logic [WIDTH-1:0] sum_fin;
    always_comb begin
        sum_fin = r_next;
        if (co ^ c_msb)
            sum_fin = a_q[CHUNK-1] ? SMIN : SMAX;
    end
`else
    logic [WIDTH-1:0] sum_fin;
    assign sum_fin = r_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            r_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state <= RUN;
                        a_q   <= bus.a;
                        b_q   <= bus.sub ? ~bus.b : bus.b;
                        c_q   <= bus.cin ^ bus.sub;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_q <= a_q >> CHUNK;
                    b_q <= b_q >> CHUNK;
                    c_q <= co;
                    r_q <= r_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        sum_q  <= sum_fin;
                        cout_q <= co;
                        ovf_q  <= co ^ c_msb;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_add_serial.sv
// Scoreboard bench for add_serial: directed vectors, queued expectations.
module tb_add_serial;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    exp_t q[$];

    add_serial_if #(.WIDTH(W)) bus ();

    add_serial #(.WIDTH(W), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
    endtask

    // Called at a negedge; start is sampled at the next posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] es, input logic ec,
                         input logic eo);
        exp_t e;
        drive(a, b, cin, sub);
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.cyc  = cyc + 5;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic monitor_step();
        exp_t e;
        if (rst_n) begin
            if (bus.done) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1, expected 0 (sum %h)",
                             bus.sum);
                end else begin
                    e = q.pop_front();
                    chk("latency", W'(cyc), W'(e.cyc));
                    chk("sum", bus.sum, e.sum);
                    chk("cout", W'(bus.cout), W'(e.cout));
                    chk("ovf", W'(bus.ovf), W'(e.ovf));
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                tests++;
                fails++;
                $display("FAIL done_timeout: got no done by cycle %0d, expected at %0d",
                         cyc, e.cyc);
            end
        end
    endtask

    logic [W-1:0] sat_p;
    logic [W-1:0] sat_n;
    logic [W-1:0] sat_z;

    initial begin
`ifdef ADD_SERIAL_SAT_EN
        sat_p = 16'h7FFF;
        sat_n = 16'h8000;
        sat_z = 16'h8000;
`else
        sat_p = 16'h8000;
        sat_n = 16'h7FFF;
        sat_z = 16'h0000;
`endif
        cyc       = 0;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        #1;
        chk("rst_busy", W'(bus.busy), '0);
        chk("rst_done", W'(bus.done), '0);
        chk("rst_sum", bus.sum, '0);
        chk("rst_cout_ovf", W'({bus.cout, bus.ovf}), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            begin
                issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
                chk("busy_c1", W'(bus.busy), W'(1));
                repeat (3) @(negedge clk);
                chk("busy_c4", W'(bus.busy), W'(1));
                @(negedge clk);
                chk("busy_done", W'(bus.busy), '0);
                @(negedge clk);

                issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
                repeat (5) @(negedge clk);
                issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, sat_p, 1'b0, 1'b1);
                repeat (5) @(negedge clk);
                issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
                repeat (5) @(negedge clk);
                issue(16'h8000, 16'h0001, 1'b0, 1'b1, sat_n, 1'b1, 1'b1);
                repeat (5) @(negedge clk);
                issue(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
                repeat (5) @(negedge clk);
                issue(16'h8000, 16'h8000, 1'b0, 1'b0, sat_z, 1'b1, 1'b1);
                repeat (5) @(negedge clk);

                // start mid-RUN with other operands must be ignored
                issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
                drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
                @(negedge clk);
                bus.start = 1'b0;
                repeat (6) @(negedge clk);

                // back-to-back: start in the DONE cycle
                issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
                repeat (4) @(negedge clk);
                issue(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
                repeat (6) @(negedge clk);

                // reset mid-RUN aborts with no done
                drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
                @(negedge clk);
                bus.start = 1'b0;
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("abort_busy", W'(bus.busy), '0);
                chk("abort_sum", bus.sum, '0);
                chk("abort_cout_ovf", W'({bus.cout, bus.ovf}), '0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (6) @(negedge clk);
                chk("abort_idle", W'({bus.busy, bus.done}), '0);

                issue(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
                repeat (10) @(negedge clk);
            end
        join_any
        disable fork;

        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending results, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/add_serial.md
Name: add_serial

Overview:
- Multi-cycle, parametrised adder/subtractor built from a chain of 1-bit full-adder cells.
- Processes CHUNK bits per clock, LSB chunk first, with a registered carry between chunks.
- Trades latency for area; it is the arithmetic core for narrow datapaths that need WIDTH-bit add/sub.
- Handshake: start / busy / done.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- Derived localparam NCHUNK = WIDTH/CHUNK. Counter width is clog2(NCHUNK), minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when the FSM is IDLE or DONE.
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in (add) or borrow-in (sub), sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held stable from the done pulse until the next done.
- cout  output  1  carry-out; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, cout, ovf = 0; sum = 0; internal shift registers and counter = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1 -> RUN. Latch a into the A shift register and (sub ? ~b : b) into the B shift register. Carry register = sub ? ~cin : cin. Counter = 0.
  - RUN: each edge adds the low CHUNK bits of A, B and the carry through the CHUNK-bit ripple. Shift the resulting chunk into the top of the result register. Shift A and B right by CHUNK. Update carry. Counter++.
  - RUN, on the edge where the counter = NCHUNK-1 -> DONE. On the same edge: sum <= final result; cout <= final carry; ovf <= carry-into-MSB XOR carry-out-of-MSB.
  - DONE lasts exactly one cycle, with done=1. start=1 -> RUN (back-to-back, same latching as IDLE); otherwise -> IDLE.
- Latency: done is high in the cycle that begins NCHUNK rising edges after the edge that sampled start. With defaults this is 4 edges.
- start while busy=1 is ignored; no queuing.
- sum, cout and ovf change only on the edge that enters DONE. They do not change during RUN.
- Reset asserted mid-RUN aborts the operation. No done is produced and all outputs go to 0.
- CHUNK = WIDTH gives a single RUN cycle (NCHUNK=1). CHUNK = 1 gives a pure bit-serial adder.

Optional Feature:
- Macro ADD_SERIAL_SAT_EN.
- When defined: if ovf=1 on the DONE edge, sum is saturated.
  - Positive overflow (sign of the true result = 0, i.e. final carry-out = 0 for add-of-positives) gives 0x7F..F.
  - Negative overflow gives 0x80..0.
  - Saturation direction is the sign of the A operand's MSB: A MSB=0 -> max positive, A MSB=1 -> min negative.
  - ovf and cout still report the unsaturated values.
- When undefined: sum is the wrapped result. No extra logic is present.

Decomposition:
- Package add_pkg holds:
  - localparam defaults ADD_WIDTH_DEF=16 and ADD_CHUNK_DEF=4;
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module add_chunk, parametrised by CHUNK: purely combinational ripple of CHUNK full-adder cells. Outputs are the CHUNK-bit sum, the carry-out, and the carry into its top bit (needed for ovf).
- add_serial instantiates one add_chunk and contains the FSM, shift registers and result registers.

Test Plan:
- Defaults. sub=0, a=16'h1234, b=16'h4321, cin=0 -> done exactly 4 edges after start; sum=16'h5555, cout=0, ovf=0; busy high for 4 cycles.
- a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> sum=16'h0000, cout=1, ovf=0.
- a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, cout=0, ovf=1. With ADD_SERIAL_SAT_EN: sum=16'h7FFF.
- sub=1, a=16'h0005, b=16'h0007, cin=0 -> sum=16'hFFFE, cout=0, ovf=0.
- sub=1, a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1. With ADD_SERIAL_SAT_EN: sum=16'h8000.
- Control boundaries:
  - start pulsed mid-RUN with different operands -> ignored; first result unchanged.
  - start held high in the DONE cycle -> second operation runs; second done 4 edges later.
  - rst_n low for 1 cycle mid-RUN -> no done; outputs 0; FSM back to IDLE.
